// File: rtl/hazard_detect_unit.sv
// ID-stage load-use / branch-operand hazard detector with a 1- or 2-cycle stall FSM.
// Optional saturating stall/flush statistics when HAZARD_STATS_EN is defined.
module hazard_detect_unit #(
    parameter int unsigned REG_W   = 5,
    parameter int unsigned CNT_W   = 2,
    parameter int unsigned STATS_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rt,
    input  logic             id_branch,
    input  logic             pc_src,
    input  logic             ex_memread,
    input  logic             ex_regwrite,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             mem_memread,
    input  logic [REG_W-1:0] mem_rd,
    output logic             hazard,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush
`ifdef HAZARD_STATS_EN
    ,
    output logic [STATS_W-1:0] stall_cycles,
    output logic [STATS_W-1:0] flush_count
`endif
);

    typedef enum logic [0:0] {StIdle, StStall} state_e;

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;

    logic ex_match;
    logic mem_match;
    logic need_two;
    logic need_one;

    // $zero is never a real producer, so it cannot create a dependency.
    assign ex_match  = (ex_rd != '0) &&
                       ((ex_rd == id_rs) || (id_uses_rt && (ex_rd == id_rt)));
    assign mem_match = (mem_rd != '0) &&
                       ((mem_rd == id_rs) || (id_uses_rt && (mem_rd == id_rt)));

    assign need_two = id_branch && ex_memread && ex_match;
    assign need_one = (ex_memread && ex_match) ||
                      (id_branch && ex_regwrite && ex_match) ||
                      (id_branch && mem_memread && mem_match);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    // Single stalls re-evaluate in IDLE; only the load->branch case needs STALL.
                    if (need_two) begin
                        state_q <= StStall;
                        cnt_q   <= CNT_W'(1);
                    end
                end
                StStall: begin
                    cnt_q <= cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_q <= StIdle;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    always_comb begin
        hazard = 1'b0;
        if (!reset) begin
            hazard = (state_q == StStall) || need_two || need_one;
        end
        pc_write   = !hazard;
        ifid_write = !hazard;
        // A branch held by a stall has not really resolved yet, so it must not flush.
        ifid_flush = !reset && pc_src && !hazard;
    end

`ifdef HAZARD_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cycles <= '0;
            flush_count  <= '0;
        end else begin
            if (hazard && (stall_cycles != '1)) begin
                stall_cycles <= stall_cycles + STATS_W'(1);
            end
            if (ifid_flush && (flush_count != '1)) begin
                flush_count <= flush_count + STATS_W'(1);
            end
        end
    end
`else
    // Statistics width only matters when the counters are built.
    if (STATS_W == 0) begin : g_stats_w_unused
    end
`endif

endmodule

// File: tb/tb_hazard_detect_unit.sv
// Directed bench for hazard_detect_unit: a remaining-stalls model checked every cycle,
// plus literal expectations at key points of each scenario.
module tb_hazard_detect_unit;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] id_rs, id_rt, ex_rd, mem_rd;
    logic       id_uses_rt, id_branch, pc_src, ex_memread, ex_regwrite, mem_memread;
    logic       hazard, pc_write, ifid_write, ifid_flush;
`ifdef HAZARD_STATS_EN
    logic [15:0] stall_cycles, flush_count;
`endif

    int pass_cnt  = 0;
    int total_cnt = 0;

    hazard_detect_unit #(.REG_W(5), .CNT_W(2), .STATS_W(16)) dut (
        .clk         (clk),
        .reset       (reset),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .id_uses_rt  (id_uses_rt),
        .id_branch   (id_branch),
        .pc_src      (pc_src),
        .ex_memread  (ex_memread),
        .ex_regwrite (ex_regwrite),
        .ex_rd       (ex_rd),
        .mem_memread (mem_memread),
        .mem_rd      (mem_rd),
        .hazard      (hazard),
        .pc_write    (pc_write),
        .ifid_write  (ifid_write),
        .ifid_flush  (ifid_flush)
`ifdef HAZARD_STATS_EN
        ,
        .stall_cycles(stall_cycles),
        .flush_count (flush_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got %0h required %0h at %0t", name, got, exp, $time);
    endtask

    // Model: number of stall cycles still owed after the current one.
    int rem = 0;
    int m_stall = 0;
    int m_flush = 0;

    function automatic bit dep(input logic [4:0] r);
        return (r != 0) && ((r == id_rs) || (id_uses_rt && (r == id_rt)));
    endfunction

    function automatic int need();
        if (id_branch && ex_memread && dep(ex_rd)) return 2;
        if (ex_memread && dep(ex_rd)) return 1;
        if (id_branch && ex_regwrite && dep(ex_rd)) return 1;
        if (id_branch && mem_memread && dep(mem_rd)) return 1;
        return 0;
    endfunction

    function automatic bit exp_hazard();
        if (reset) return 1'b0;
        if (rem > 0) return 1'b1;
        return need() > 0;
    endfunction

    function automatic bit exp_flush();
        return !reset && pc_src && !exp_hazard();
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            rem     <= 0;
            m_stall <= 0;
            m_flush <= 0;
        end else begin
            if (exp_hazard() && m_stall < 65535) m_stall <= m_stall + 1;
            if (exp_flush() && m_flush < 65535) m_flush <= m_flush + 1;
            if (rem > 0) rem <= rem - 1;
            else rem <= (need() == 2) ? 1 : 0;
        end
    end

    always @(negedge clk) begin
        chk("hazard", 32'(hazard), 32'(exp_hazard()));
        chk("pc_write", 32'(pc_write), 32'(!exp_hazard()));
        chk("ifid_write", 32'(ifid_write), 32'(!exp_hazard()));
        chk("ifid_flush", 32'(ifid_flush), 32'(exp_flush()));
`ifdef HAZARD_STATS_EN
        chk("stall_cycles", 32'(stall_cycles), 32'(m_stall));
        chk("flush_count", 32'(flush_count), 32'(m_flush));
`endif
    end

    task automatic clr();
        id_rs = 0; id_rt = 0; ex_rd = 0; mem_rd = 0;
        id_uses_rt = 0; id_branch = 0; pc_src = 0;
        ex_memread = 0; ex_regwrite = 0; mem_memread = 0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic lit(input string name, input logic h, input logic f);
        #1;
        chk({name, "_hazard"}, 32'(hazard), 32'(h));
        chk({name, "_pc_write"}, 32'(pc_write), 32'(!h));
        chk({name, "_ifid_flush"}, 32'(ifid_flush), 32'(f));
    endtask

    task automatic load_branch();
        clr();
        id_branch = 1; ex_memread = 1; ex_rd = 9; id_rt = 9; id_uses_rt = 1; id_rs = 2;
    endtask

    initial begin
        clr();
        reset = 1;
        // Reset masks a live load-use and a taken branch.
        ex_memread = 1; ex_rd = 8; id_rs = 8; pc_src = 1;
        lit("reset_mask", 1'b0, 1'b0);
        cyc(); cyc();
        reset = 0; clr();
        lit("idle", 1'b0, 1'b0);
        cyc();

        // Load-use: one stall, then EX holds a bubble.
        ex_memread = 1; ex_rd = 8; id_rs = 8;
        lit("load_use", 1'b1, 1'b0);
        cyc(); clr();
        lit("load_use_done", 1'b0, 1'b0);
        cyc();

        // Load->branch on rt: exactly two stalls, second one from the FSM alone.
        load_branch();
        lit("ld_br_1", 1'b1, 1'b0);
        cyc(); clr();
        lit("ld_br_2", 1'b1, 1'b0);
        cyc();
        lit("ld_br_done", 1'b0, 1'b0);
        cyc();

        // $zero never matches.
        ex_memread = 1; ex_rd = 0; id_rs = 0;
        lit("zero_reg", 1'b0, 1'b0);
        cyc(); clr();

        // rt ignored when the instruction does not read it.
        ex_memread = 1; ex_rd = 7; id_rt = 7; id_rs = 1;
        lit("rt_unused", 1'b0, 1'b0);
        cyc(); clr();

        // Taken branch flushes; taken branch under load-use does not.
        pc_src = 1;
        lit("flush", 1'b0, 1'b1);
        cyc();
        ex_memread = 1; ex_rd = 8; id_rs = 8;
        lit("flush_blocked", 1'b1, 1'b0);
        cyc(); clr();

        // Branch on ALU result in EX and on a load in MEM: one stall each.
        id_branch = 1; ex_regwrite = 1; ex_rd = 3; id_rs = 3;
        lit("br_alu", 1'b1, 1'b0);
        cyc(); clr();
        id_branch = 1; mem_memread = 1; mem_rd = 4; id_rt = 4; id_uses_rt = 1;
        lit("br_mem_load", 1'b1, 1'b0);
        cyc(); clr();
        // Non-branch does not care about ALU producers.
        ex_regwrite = 1; ex_rd = 3; id_rs = 3;
        lit("alu_fwd", 1'b0, 1'b0);
        cyc(); clr();

        // Reset in the first stall cycle.
        load_branch(); reset = 1;
        lit("rst_stall1", 1'b0, 1'b0);
        cyc(); reset = 0; clr();
        lit("rst_stall1_after", 1'b0, 1'b0);
        cyc();

        // Reset while the FSM is in STALL.
        load_branch();
        lit("rst_stall2_pre", 1'b1, 1'b0);
        cyc(); clr(); reset = 1;
        lit("rst_stall2", 1'b0, 1'b0);
        cyc(); reset = 0;
        lit("rst_stall2_after", 1'b0, 1'b0);
        cyc();

`ifdef HAZARD_STATS_EN
        reset = 1; cyc(); reset = 0;
        ex_memread = 1; ex_rd = 8; id_rs = 8;
        cyc(); clr();
        load_branch();
        cyc(); clr();
        cyc();
        pc_src = 1;
        cyc(); clr();
        #1;
        chk("stats_stall_lit", 32'(stall_cycles), 32'd3);
        chk("stats_flush_lit", 32'(flush_count), 32'd1);
        cyc();
`endif

        cyc();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
